// File: rtl/ps2_host_transmitter_if.sv
// ps2_host_transmitter_if: command-byte handshake and status between host logic and the PS/2 transmitter
interface ps2_host_transmitter_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_error;
  logic busy;
  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error, busy);
  modport slave (input tx_data, tx_valid, output tx_ready, tx_done, tx_error, busy);
endinterface

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: open-drain PS/2 host-to-device command transmitter with filtered device clock and ACK check
module ps2_host_transmitter #(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd1000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd200000,
  parameter int FILTER_LEN = 4
) (
  input logic clock,
  input logic reset,
  input logic device_clock_i,
  input logic device_data_i,
  output logic device_clock_pull_o,
  output logic device_data_pull_o,
  ps2_host_transmitter_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, DATA, PARITY, STOP, ACK, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_s_q, dat_s_q;
  logic clk_f_q, clk_f_d, fall_q, fall_d;
  logic [FW-1:0] flt_q, flt_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [2:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [19:0] to_q, to_d;
  logic clk_pull_q, clk_pull_d, dat_pull_q, dat_pull_d;
  logic done_q, done_d, err_q, err_d;
  logic timed;
  assign device_clock_pull_o = clk_pull_q;
  assign device_data_pull_o = dat_pull_q;
  assign bus.tx_ready = state_q == IDLE;
  assign bus.tx_done = done_q;
  assign bus.tx_error = err_q;
  assign bus.busy = state_q != IDLE || done_q || err_q;
  always_comb begin
    state_d = state_q;
    clk_f_d = clk_f_q;
    flt_d = '0;
    shift_d = shift_q;
    par_d = par_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    to_d = to_q;
    clk_pull_d = clk_pull_q;
    dat_pull_d = dat_pull_q;
    done_d = 1'b0;
    err_d = 1'b0;
    timed = state_q inside {DATA, PARITY, STOP, ACK, WAIT_IDLE};
    // the filtered level only moves after FILTER_LEN consecutive disagreeing samples
    if (clk_s_q[1] != clk_f_q) begin
      flt_d = flt_q == FW'(FILTER_LEN - 1) ? '0 : flt_q + FW'(1);
      clk_f_d = flt_q == FW'(FILTER_LEN - 1) ? clk_s_q[1] : clk_f_q;
    end
    fall_d = clk_f_q & ~clk_f_d;
    if (timed) to_d = fall_q ? '0 : to_q + 20'd1;
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        shift_d = bus.tx_data;
        par_d = ~^bus.tx_data;
        cnt_d = '0;
        clk_pull_d = 1'b1;
        state_d = INHIBIT;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == INHIBIT_CYCLES - 16'd1) begin
          dat_pull_d = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        clk_pull_d = 1'b0;
        idx_d = '0;
        to_d = '0;
        state_d = DATA;
      end
      DATA: if (fall_q) begin
        dat_pull_d = ~shift_q[idx_q];
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? PARITY : DATA;
      end
      PARITY: if (fall_q) begin
        dat_pull_d = ~par_q;
        state_d = STOP;
      end
      STOP: if (fall_q) begin
        dat_pull_d = 1'b0;
        state_d = ACK;
      end
      ACK: if (fall_q) begin
        err_d = dat_s_q[1];
        state_d = dat_s_q[1] ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_f_q && dat_s_q[1]) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a silent device aborts the frame and frees the bus; a fall in the same cycle wins
    if (timed && !fall_q && to_q == TIMEOUT_CYCLES - 20'd1) begin
      clk_pull_d = 1'b0;
      dat_pull_d = 1'b0;
      done_d = 1'b0;
      err_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      clk_f_q <= 1'b1;
      fall_q <= 1'b0;
      flt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      clk_pull_q <= 1'b0;
      dat_pull_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_s_q <= {clk_s_q[0], device_clock_i};
      dat_s_q <= {dat_s_q[0], device_data_i};
      clk_f_q <= clk_f_d;
      fall_q <= fall_d;
      flt_q <= flt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      clk_pull_q <= clk_pull_d;
      dat_pull_q <= dat_pull_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb_ps2_host_transmitter: table-driven frames against an open-drain PS/2 device model, plus timeout and reset sequences
module tb_ps2_host_transmitter;
  localparam int INH = 20;
  localparam int TO = 300;
  localparam int HP = 25;
  typedef struct {
    logic [7:0] d;
    logic ack;
    logic hold;
    logic par;
    logic done;
    logic err;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic clk_pull, dat_pull, ps2_clk, ps2_dat;
  logic prev_pulse = 1'b0;
  int vecs = 0;
  int fails = 0;
  int done_n = 0;
  int err_n = 0;
  vec_t tbl[7];
  assign ps2_clk = ~clk_pull & dev_clk;
  assign ps2_dat = ~dat_pull & dev_dat;
  ps2_host_transmitter_if bus();
  ps2_host_transmitter #(
    .INHIBIT_CYCLES(16'(INH)),
    .TIMEOUT_CYCLES(20'(TO)),
    .FILTER_LEN(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .device_clock_i(ps2_clk),
    .device_data_i(ps2_dat),
    .device_clock_pull_o(clk_pull),
    .device_data_pull_o(dat_pull),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset) prev_pulse <= 1'b0;
    else begin
      if (bus.tx_done || bus.tx_error) begin
        done_n += 32'(bus.tx_done);
        err_n += 32'(bus.tx_error);
        chk("pulse_busy", 32'(bus.busy), 32'd1);
        chk("pulse_ready", 32'(bus.tx_ready), 32'd1);
        chk("pulse_exclusive", 32'(bus.tx_done & bus.tx_error), 32'd0);
        chk("pulse_width", 32'(prev_pulse), 32'd0);
      end
      prev_pulse <= bus.tx_done | bus.tx_error;
    end
  end
  // device side: waits for the host to free the clock, then clocks np bits sampling data on rising edges
  task automatic device(input int np, input logic ack, output logic [9:0] bits, output logic ok);
    int n = 0;
    bits = '0;
    while (clk_pull && n < 1000) begin
      @(negedge clock);
      n++;
    end
    ok = !clk_pull;
    if (!ok) return;
    repeat (HP) @(negedge clock);
    for (int i = 0; i < np; i++) begin
      dev_clk = 1'b0;
      if (i == 10 && ack) dev_dat = 1'b0;
      repeat (HP) @(negedge clock);
      dev_clk = 1'b1;
      if (i < 10) bits[i] = ps2_dat;
      dev_dat = 1'b1;
      if (i < np - 1) repeat (HP) @(negedge clock);
    end
  endtask
  task automatic request(input logic [7:0] d, input logic hold);
    int n = 0;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clock);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("ready_low", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = hold;
    if (hold) bus.tx_data = 8'h3C;
    n = 0;
    while (clk_pull && !dat_pull && n < 1000) begin
      n++;
      @(negedge clock);
    end
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("start_bit", 32'({clk_pull, dat_pull}), 32'd3);
  endtask
  task automatic run_vec(input vec_t v);
    logic [9:0] bits;
    logic ok;
    int n, d0, e0;
    d0 = done_n;
    e0 = err_n;
    request(v.d, v.hold);
    device(11, v.ack, bits, ok);
    chk("clock_release", 32'(ok), 32'd1);
    bus.tx_valid = 1'b0;
    n = 0;
    while (done_n + err_n == d0 + e0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("frame", 32'(bits), 32'({1'b1, v.par, v.d}));
    chk("done_count", 32'(done_n - d0), 32'(v.done));
    chk("error_count", 32'(err_n - e0), 32'(v.err));
    chk("idle_pulls", 32'({clk_pull, dat_pull}), 32'd0);
    chk("idle_ready", 32'(bus.tx_ready), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
  initial begin
    logic [9:0] bits;
    logic ok;
    int n, d0, e0;
    tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hF4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'hF4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_pulls", 32'({clk_pull, dat_pull}), 32'd0);
    chk("reset_ready", 32'(bus.tx_ready), 32'd1);
    chk("reset_pulses", 32'({bus.tx_done, bus.tx_error, bus.busy}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    // device never clocks: abort exactly TO cycles after the clock is released
    d0 = done_n;
    e0 = err_n;
    request(8'h55, 1'b0);
    n = 0;
    while (clk_pull && n < 10) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!bus.tx_error && n < 2 * TO) begin
      n++;
      @(negedge clock);
    end
    chk("timeout_len", 32'(n), 32'(TO));
    @(negedge clock);
    chk("timeout_err", 32'(err_n - e0), 32'd1);
    chk("timeout_no_done", 32'(done_n - d0), 32'd0);
    chk("timeout_pulls", 32'({clk_pull, dat_pull}), 32'd0);
    chk("timeout_ready", 32'(bus.tx_ready), 32'd1);
    // reset while the device holds the 4th clock low and the host pulls data for bit 3
    d0 = done_n;
    e0 = err_n;
    request(8'h81, 1'b0);
    device(3, 1'b1, bits, ok);
    chk("partial_release", 32'(ok), 32'd1);
    repeat (HP) @(negedge clock);
    dev_clk = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_reset_bit3", 32'(dat_pull), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pulls", 32'({clk_pull, dat_pull}), 32'd0);
    chk("async_reset_ready", 32'(bus.tx_ready), 32'd1);
    chk("async_reset_outs", 32'({bus.tx_done, bus.tx_error, bus.busy}), 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_no_pulse", 32'(done_n - d0 + err_n - e0), 32'd0);
    run_vec(tbl[2]);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
